// File: rtl/rcg_pkg.sv
// Shared types and constants for the rcg_seq reset sequencer and its per-domain dividers.
package rcg_pkg;

  typedef enum logic [1:0] {SYNC, GAP, REL, DONE} rcg_state_e;

  localparam int DEF_RATIO = 1;
  localparam int MAX_DOM   = 8;

  // Counter/index width that never collapses to zero bits.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/rcg_div.sv
// One domain's clock-enable divider: ratio latch, phase counter, gating by domain reset.
module rcg_div
  import rcg_pkg::*;
#(
  parameter int DIV_W = 8
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             dom_rst,
  input  logic             dom_rst_nxt,
  input  logic             load,
  input  logic [DIV_W-1:0] ratio_in,
  output logic             clk_en
);

  logic [DIV_W-1:0] ratio;
  logic [DIV_W-1:0] cnt;
  logic             ratio_le1;

  assign ratio_le1 = (ratio <= DIV_W'(1));

  // dom_rst_nxt lets the enable rise on the very edge the domain is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ratio  <= DIV_W'(DEF_RATIO);
      cnt    <= '0;
      clk_en <= 1'b0;
    end else begin
      if (load) ratio <= ratio_in;
      if (dom_rst_nxt || load) begin
        cnt    <= '0;
        clk_en <= 1'b0;
      end else if (ratio_le1) begin
        cnt    <= '0;
        clk_en <= 1'b1;
      end else if (dom_rst) begin
        cnt    <= '0;
        clk_en <= 1'b0;
      end else if (cnt == ratio - DIV_W'(1)) begin
        cnt    <= '0;
        clk_en <= 1'b1;
      end else begin
        cnt    <= cnt + DIV_W'(1);
        clk_en <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/rcg_seq.sv
// Reset synchroniser, staggered domain release FSM and per-domain clock-enable dividers.
// Optional soft-reset/skip path built only when RCG_SEQ_SOFT_RST_EN is defined.
module rcg_seq
  import rcg_pkg::*;
#(
  parameter int NUM_DOM     = 3,
  parameter int SYNC_STAGES = 2,
  parameter int REL_GAP     = 16,
  parameter int DIV_W       = 8
)(
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic [NUM_DOM*DIV_W-1:0] div_ratio,
  input  logic [NUM_DOM-1:0]       div_load,
  input  logic [NUM_DOM-1:0]       soft_rst_req,
  output logic [NUM_DOM-1:0]       dom_rst,
  output logic [NUM_DOM-1:0]       dom_clk_en,
  output logic                     seq_done
);

  localparam int IDX_W = clog2_min1(NUM_DOM);
  localparam int GAP_W = clog2_min1(REL_GAP);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(REL_GAP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DOM - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rst_s;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) sync_q <= '1;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
  end

  assign rst_s = sync_q[SYNC_STAGES-1];

  rcg_state_e       state;
  logic [IDX_W-1:0] dom_idx;
  logic [GAP_W-1:0] gap_cnt;
  logic             rel_fire;
  logic             to_done;

  // REL is the first cycle of the next gap, so releases stay exactly REL_GAP apart.
  assign rel_fire = ((state == GAP) || (state == REL)) && (gap_cnt == GAP_LAST);
  assign to_done  = (state == DONE) || (rel_fire && (dom_idx == IDX_LAST));

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state   <= SYNC;
      dom_idx <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        SYNC: if (!rst_s) begin
          state   <= GAP;
          gap_cnt <= '0;
        end
        GAP, REL: if (rel_fire) begin
          gap_cnt <= '0;
          if (dom_idx == IDX_LAST) state <= DONE;
          else begin
            state   <= REL;
            dom_idx <= dom_idx + IDX_W'(1);
          end
        end else begin
          state   <= GAP;
          gap_cnt <= gap_cnt + GAP_W'(1);
        end
        DONE:    state <= DONE;
        default: state <= SYNC;
      endcase
    end
  end

  logic [NUM_DOM-1:0] seq_sel;
  logic [NUM_DOM-1:0] rel_req;
  logic [NUM_DOM-1:0] set_req;
  logic [NUM_DOM-1:0] dom_rst_nxt;

  always_comb begin
    seq_sel = '0;
    for (int i = 0; i < NUM_DOM; i++)
      seq_sel[i] = rel_fire && (dom_idx == IDX_W'(i));
  end

`ifdef RCG_SEQ_SOFT_RST_EN
  logic [NUM_DOM-1:0]            req_q;
  logic [NUM_DOM-1:0]            skipped;
  logic [NUM_DOM-1:0]            soft_act;
  logic [NUM_DOM-1:0]            soft_rel;
  logic [NUM_DOM-1:0][GAP_W-1:0] soft_cnt;

  // A domain skipped by the sequence is owned by the soft path from then on.
  assign soft_act = {NUM_DOM{state == DONE}} | skipped;

  always_comb begin
    soft_rel = '0;
    for (int i = 0; i < NUM_DOM; i++)
      soft_rel[i] = soft_act[i] & ~req_q[i] & dom_rst[i] & (soft_cnt[i] == GAP_LAST);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      req_q    <= '0;
      skipped  <= '0;
      soft_cnt <= '0;
    end else begin
      req_q   <= soft_rst_req;
      skipped <= skipped | (seq_sel & req_q);
      for (int i = 0; i < NUM_DOM; i++) begin
        if (!soft_act[i] || req_q[i] || !dom_rst[i] || soft_rel[i]) soft_cnt[i] <= '0;
        else                                                        soft_cnt[i] <= soft_cnt[i] + GAP_W'(1);
      end
    end
  end

  assign rel_req = (seq_sel & ~req_q) | soft_rel;
  assign set_req = soft_act & req_q;
`else
  logic unused_soft_req;
  assign unused_soft_req = ^soft_rst_req;
  assign rel_req         = seq_sel;
  assign set_req         = '0;
`endif

  assign dom_rst_nxt = (dom_rst & ~rel_req) | set_req;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      dom_rst  <= '1;
      seq_done <= 1'b0;
    end else begin
      dom_rst  <= dom_rst_nxt;
      seq_done <= to_done & ~|dom_rst_nxt;
    end
  end

  rcg_div #(.DIV_W(DIV_W)) u_div [NUM_DOM-1:0] (
    .clk         (sys_clk),
    .rst         (sys_rst),
    .dom_rst     (dom_rst),
    .dom_rst_nxt (dom_rst_nxt),
    .load        (div_load),
    .ratio_in    (div_ratio),
    .clk_en      (dom_clk_en)
  );

endmodule

// File: tb/tb_rcg_seq.sv
// Bench for rcg_seq: directed power-on/divider/skip timeline plus random loads, soft requests
// and async reset pulses, all checked every cycle against an edge-indexed reference model.
module tb_rcg_seq;

  localparam int N  = 3;
  localparam int S  = 2;
  localparam int R  = 16;
  localparam int DW = 8;

`ifdef RCG_SEQ_SOFT_RST_EN
  localparam bit SOFT = 1'b1;
`else
  localparam bit SOFT = 1'b0;
`endif

  logic            sys_clk = 1'b0;
  logic            sys_rst = 1'b0;
  logic [N*DW-1:0] div_ratio = '0;
  logic [N-1:0]    div_load = '0;
  logic [N-1:0]    soft_rst_req = '0;
  logic [N-1:0]    dom_rst;
  logic [N-1:0]    dom_clk_en;
  logic            seq_done;

  rcg_seq #(.NUM_DOM(N), .SYNC_STAGES(S), .REL_GAP(R), .DIV_W(DW)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .div_ratio    (div_ratio),
    .div_load     (div_load),
    .soft_rst_req (soft_rst_req),
    .dom_rst      (dom_rst),
    .dom_clk_en   (dom_clk_en),
    .seq_done     (seq_done)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: n is the edge index counted from the first edge with sys_rst low.
  int           n;
  logic [N-1:0] m_rst, m_en, m_skip, m_req;
  logic         m_done;
  int           low_start [N];
  int           anch      [N];
  int           ratio     [N];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, n);
    end
  endtask

  task automatic model_reset();
    n      = -1;
    m_rst  = '1;
    m_en   = '0;
    m_done = 1'b0;
    m_skip = '0;
    m_req  = '0;
    for (int i = 0; i < N; i++) begin
      low_start[i] = 0;
      anch[i]      = 0;
      ratio[i]     = 1;
    end
  endtask

  task automatic model_edge();
    logic [N-1:0] nr;
    int done_at;
    if (sys_rst) begin
      model_reset();
      return;
    end
    n++;
    done_at = S + N * R;
    nr = m_rst;
    for (int i = 0; i < N; i++) begin
      bit active;
      active = SOFT && ((n - 1 >= done_at) || m_skip[i]);
      if (n == S + (i + 1) * R) begin
        if (SOFT && m_req[i]) m_skip[i] = 1'b1;
        else                  nr[i] = 1'b0;
      end
      if (active) begin
        if (m_req[i])                               nr[i] = 1'b1;
        else if (m_rst[i] && (n - low_start[i] == R)) nr[i] = 1'b0;
      end
    end
    m_done = (n >= done_at) && (nr == '0);
    for (int i = 0; i < N; i++) begin
      logic ld;
      ld = div_load[i];
      if (!nr[i] && (ld || m_rst[i])) anch[i] = n;
      m_en[i] = !nr[i] && !ld &&
                (ratio[i] <= 1 || (n != anch[i] && ((n - anch[i]) % ratio[i]) == 0));
      if (ld) ratio[i] = int'(div_ratio[i*DW +: DW]);
    end
    for (int i = 0; i < N; i++)
      if (m_req[i] && !soft_rst_req[i]) low_start[i] = n;
    m_req = soft_rst_req;
    m_rst = nr;
  endtask

  task automatic check_model();
    chk("dom_rst", dom_rst, m_rst);
    chk("dom_clk_en", dom_clk_en, m_en);
    chk("seq_done", seq_done, m_done);
  endtask

  task automatic cycle();
    @(posedge sys_clk);
    model_edge();
    #1;
    check_model();
  endtask

  // Async pulse inside one clock period; called just after a checked edge.
  task automatic pulse_reset();
    #2 sys_rst = 1'b1;
    #1;
    model_reset();
    chk("arst_dom_rst", dom_rst, {N{1'b1}});
    chk("arst_clk_en", dom_clk_en, '0);
    chk("arst_seq_done", seq_done, 1'b0);
    #2 sys_rst = 1'b0;
  endtask

  initial begin
    int nx;
    sys_rst = 1'b1;
    model_reset();
    #1;
    check_model();
    for (int k = 0; k < 3; k++) cycle();
    sys_rst = 1'b0;

    // Power-on timeline, divider loads and a soft request after DONE
    while (n < 140) begin
      nx = n + 1;
      div_load = '0;
      if (nx == 5) begin
        div_ratio = {8'd2, 8'd4, 8'd0};
        div_load  = 3'b111;
      end
      if (nx == 60) begin
        div_ratio[DW +: DW] = 8'd3;
        div_load            = 3'b010;
      end
      if (nx == 100) soft_rst_req[2] = 1'b1;
      if (nx == 120) soft_rst_req[2] = 1'b0;
      cycle();
      case (n)
        17: chk("pre_rel0", dom_rst, 3'b111);
        18: begin chk("rel0", dom_rst, 3'b110); chk("en0_r0", dom_clk_en[0], 1'b1); end
        33: chk("pre_rel1", dom_rst, 3'b110);
        34: chk("rel1", dom_rst, 3'b100);
        37: chk("en1_pre", dom_clk_en[1], 1'b0);
        38: chk("en1_first", dom_clk_en[1], 1'b1);
        49: chk("done_pre", seq_done, 1'b0);
        50: begin chk("rel2", dom_rst, 3'b000); chk("done", seq_done, 1'b1); end
        60: chk("ld_cycle_en", dom_clk_en[1], 1'b0);
        62: chk("ld_old_phase", dom_clk_en[1], 1'b0);
        63: chk("ld_en63", dom_clk_en[1], 1'b1);
        66: chk("ld_en66", dom_clk_en[1], 1'b1);
        default: ;
      endcase
    end

    // Async reset mid-operation, with domain 0 held by soft request from reset
    div_load = '0;
    soft_rst_req = 3'b001;
    pulse_reset();
    while (n < 80) begin
      nx = n + 1;
      if (nx == 40) soft_rst_req[0] = 1'b0;
      cycle();
    end

    // Random loads, soft requests and reset pulses
    for (int k = 0; k < 700; k++) begin
      div_load = '0;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(11) == 0) begin
          div_ratio[i*DW +: DW] = DW'($urandom_range(6));
          div_load[i] = 1'b1;
        end
        if ($urandom_range(49) == 0) soft_rst_req[i] = ~soft_rst_req[i];
      end
      if ($urandom_range(249) == 0) pulse_reset();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
